scan_sequencer: RTL
===================

# scan_sequencer

Host-side sequencer for the accumulator microcontroller's scan chain and run control. It loads a program/state image byte-serially into the processor's scan chain, then runs the processor until `halt` or a cycle budget expires. Finally it dumps the whole chain back to the host non-destructively, by recirculating it. It sits between the chip I/O byte interface and the processor's `scan_enable`/`scan_in`/`scan_out`/`proc_en`/`halt` pins, and is the only driver of those pins.

## Interface
- `CHAIN_LEN`, 279: total scan-chain length in bits (control unit + PC + IR + ACC + 32x8 memory); must be at least 1.
- `CYC_W`, 16: width of the run-cycle counter and `max_cycles`.
- `clk` in 1: the single clock. All state changes on its rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: begins a load/run/dump session. Sampled only in IDLE.
- `max_cycles` in CYC_W: run budget in cycles. 0 means unlimited. Sampled on `start`.
- `load_data` in 8, `load_valid` in 1, `load_ready` out 1: byte stream into the chain.
- `dump_data` out 8, `dump_valid` out 1, `dump_ready` in 1: byte stream out of the chain.
- `scan_enable` out 1, `scan_in` out 1, `scan_out` in 1: processor scan port.
- `proc_en` out 1, `halt` in 1: processor run control.
- `busy` out 1: high in any state other than IDLE.
- `timeout` out 1: sticky; set when the budget expires, cleared on the next accepted `start`.
- `done` out 1: single-cycle pulse when the last dump byte is accepted.

## Operation
- States: IDLE -> LOAD -> RUN -> DUMP -> IDLE. `start` is ignored outside IDLE.
- **Bit order.** Stream bit k is byte k/8, bit k%8, LSB first. It is shifted on the k-th scan cycle.
- **Final byte.** Exactly ceil(CHAIN_LEN/8) bytes are transferred each way. Unused MSBs of the final load byte are discarded. Unused MSBs of the final dump byte read as 0.
- **IDLE.** All outputs are 0, except `timeout`, which holds its value.
- **LOAD.**
  - An 8-bit shift buffer plus a remaining-bit count drives the chain.
  - `load_ready` = 1 when the buffer is empty or holds its last bit, and bytes are still owed.
  - On the `load_valid && load_ready` edge, the byte is captured.
  - Each cycle the buffer is non-empty: `scan_enable` = 1, `scan_in` = buf[0], then the buffer shifts right.
  - A starved buffer gives `scan_enable` = 0; the chain holds.
  - After shift CHAIN_LEN-1 the state goes to RUN.
- **RUN.**
  - `proc_en` = 1 and `scan_enable` = 0. The cycle counter starts at 0 and increments each RUN cycle.
  - `halt` = 1 sampled -> DUMP, with `timeout` unchanged.
  - Else, if `max_cycles` != 0 and the counter reaches `max_cycles`-1 -> DUMP and `timeout` <= 1.
  - If both happen in the same cycle, `halt` wins and `timeout` stays 0.
- **DUMP.**
  - While `dump_valid` = 0 and bits remain: `scan_enable` = 1 and `scan_in` = `scan_out` (recirculate). `scan_out` is captured into the assembly register at bit position (count%8).
  - After 8 bits, or the final partial byte, `dump_valid` <= 1 with `dump_data` held stable. Shifting pauses until `dump_ready`.
  - After CHAIN_LEN shifts the chain contents equal their pre-dump value.
  - When the last byte is accepted: `done` pulses and the state goes to IDLE.
- **Reset.** Asserting `rst` in any state returns to IDLE immediately, with all outputs 0, including `timeout`. A partially loaded chain is left as-is.
- **Processor inputs.** `halt` is ignored in LOAD and DUMP. `scan_out` is ignored outside DUMP.

## Timing
- `scan_enable`, `scan_in` and `proc_en` are decoded from registered state/buffer only; there is no combinational path from `load_*` or `dump_ready`.
- `start` accepted at edge T -> LOAD from T+1. `load_ready` can be 1 in cycle T+1.
- **Load throughput.** With `load_valid` held high, the chain shifts every cycle.
  - Byte 0 is accepted at edge L; its bits shift in cycles L+1..L+8. Byte 1 is accepted at edge L+8.
  - With CHAIN_LEN bits and an uninterrupted stream, RUN begins CHAIN_LEN+1 cycles after the first accept.
- **Run.** `proc_en` is high for exactly N cycles when `halt` is first seen in the N-th RUN cycle, or when N = `max_cycles`. It is 0 the cycle after the exit decision.
- **Dump throughput.** A byte takes 8 shift cycles plus 1 valid cycle when `dump_ready` is tied high.
  - The first `dump_valid` comes 8 cycles after DUMP entry.
  - `dump_data`/`dump_valid` hold stable while `dump_ready` = 0.

## Test plan
Bench uses CHAIN_LEN=12 with a 12-bit shift-register chain model (`scan_out` = tail).
- **Load.** `start`, then bytes 0xA5, 0xFF with `load_valid` high -> `scan_in` = 1,0,1,0,0,1,0,1,1,1,1,1 on 12 consecutive `scan_enable` cycles. `load_ready` falls after the 2nd byte; RUN entered next cycle.
- **Halt.** `max_cycles`=0, `halt` raised in the 5th RUN cycle -> `proc_en` high exactly 5 cycles, `timeout`=0.
- **Timeout.** `max_cycles`=3, `halt`=0 -> `proc_en` high exactly 3 cycles, `timeout`=1, DUMP entered. `halt` and the budget coinciding in cycle 3 -> `timeout`=0.
- **Dump.** After the load above -> `dump_data` 0xA5 then 0x0F. The chain model holds its original 12 bits afterward. `done` pulses once, `busy` falls.
- **Backpressure.** `load_valid` gap of 4 cycles -> `scan_enable` low for exactly those cycles. `dump_ready` low 6 cycles -> `dump_data` stable, no shifts, no byte lost.
- **Reset.** `rst` low mid-LOAD and mid-RUN -> `scan_enable`, `proc_en`, `load_ready`, `dump_valid`, `busy`, `timeout` all 0 immediately. A new `start` after release works normally.

Source files
------------

// File: rtl/scan_sequencer_if.sv
// Byte-stream, scan-port and run-control signals between the scan sequencer,
// the host byte interface and the processor pins.
interface scan_sequencer_if #(
    parameter int CYC_W = 16
);
    logic             start;
    logic [CYC_W-1:0] max_cycles;
    logic [7:0]       load_data;
    logic             load_valid;
    logic             load_ready;
    logic [7:0]       dump_data;
    logic             dump_valid;
    logic             dump_ready;
    logic             scan_enable;
    logic             scan_in;
    logic             scan_out;
    logic             proc_en;
    logic             halt;
    logic             busy;
    logic             timeout;
    logic             done;

    modport master (
        input  start, max_cycles, load_data, load_valid, dump_ready, scan_out, halt,
        output load_ready, dump_data, dump_valid, scan_enable, scan_in, proc_en,
               busy, timeout, done
    );

    modport slave (
        output start, max_cycles, load_data, load_valid, dump_ready, scan_out, halt,
        input  load_ready, dump_data, dump_valid, scan_enable, scan_in, proc_en,
               busy, timeout, done
    );
endinterface

// File: rtl/scan_sequencer.sv
// Loads the processor scan chain byte-serially, runs it until halt or budget
// expiry, then dumps the chain to the host by recirculating it.
module scan_sequencer #(
    parameter int CHAIN_LEN = 279,
    parameter int CYC_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    scan_sequencer_if.master bus
);
    localparam int NBYTES = (CHAIN_LEN + 7) / 8;
    localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int BYTE_W = $clog2(NBYTES + 1);

    localparam logic [3:0]        LAST_BITS  = 4'(CHAIN_LEN - 8 * (NBYTES - 1));
    localparam logic [CNT_W-1:0]  LAST_SHIFT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0]  CHAIN_END  = CNT_W'(CHAIN_LEN);
    localparam logic [BYTE_W-1:0] ALL_BYTES  = BYTE_W'(NBYTES);
    localparam logic [BYTE_W-1:0] ONE_BYTE   = BYTE_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DUMP = 2'd3
    } state_e;

    state_e            state_q, state_d;
    logic [7:0]        buf_q, buf_d;
    logic [3:0]        buf_cnt_q, buf_cnt_d;
    logic [BYTE_W-1:0] owed_q, owed_d;
    logic [CNT_W-1:0]  shift_q, shift_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic [CYC_W-1:0]  max_q, max_d;
    logic              timeout_q, timeout_d;
    logic [7:0]        asm_q, asm_d;
    logic              dvalid_q, dvalid_d;

    logic              load_shift_s;
    logic              load_ready_s;
    logic              load_acc_s;
    logic              dump_shift_s;
    logic              dump_acc_s;
    logic [2:0]        pos_s;

    // shift_q counts load shifts in LOAD and dump shifts in DUMP
    assign load_shift_s = (state_q == S_LOAD) && (buf_cnt_q != 4'd0);
    assign load_ready_s = (state_q == S_LOAD) && (buf_cnt_q <= 4'd1) && (owed_q != '0);
    assign load_acc_s   = load_ready_s && bus.load_valid;
    assign dump_shift_s = (state_q == S_DUMP) && !dvalid_q && (shift_q != CHAIN_END);
    assign dump_acc_s   = dvalid_q && bus.dump_ready;
    assign pos_s        = 3'(shift_q);

    assign bus.scan_enable = load_shift_s || dump_shift_s;
    assign bus.scan_in     = load_shift_s ? buf_q[0] : (dump_shift_s ? bus.scan_out : 1'b0);
    assign bus.proc_en     = (state_q == S_RUN);
    assign bus.load_ready  = load_ready_s;
    assign bus.dump_valid  = dvalid_q;
    assign bus.dump_data   = dvalid_q ? asm_q : 8'h00;
    assign bus.busy        = (state_q != S_IDLE);
    assign bus.timeout     = timeout_q;
    assign bus.done        = dump_acc_s && (shift_q == CHAIN_END);

    // Next-state and datapath update for the load/run/dump sequence.
    always_comb begin
        state_d   = state_q;
        buf_d     = buf_q;
        buf_cnt_d = buf_cnt_q;
        owed_d    = owed_q;
        shift_d   = shift_q;
        cyc_d     = cyc_q;
        max_d     = max_q;
        timeout_d = timeout_q;
        asm_d     = asm_q;
        dvalid_d  = dvalid_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_LOAD;
                    max_d     = bus.max_cycles;
                    timeout_d = 1'b0;
                    buf_cnt_d = 4'd0;
                    owed_d    = ALL_BYTES;
                    shift_d   = '0;
                    dvalid_d  = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                // A byte captured while the last bit leaves replaces the buffer outright
                if (load_acc_s) begin
                    buf_d     = bus.load_data;
                    buf_cnt_d = (owed_q == ONE_BYTE) ? LAST_BITS : 4'd8;
                    owed_d    = owed_q - ONE_BYTE;
                end else if (load_shift_s) begin
                    buf_d     = {1'b0, buf_q[7:1]};
                    buf_cnt_d = buf_cnt_q - 4'd1;
                end else begin
                    buf_d = buf_q;
                end
                if (load_shift_s) begin
                    shift_d = shift_q + CNT_W'(1);
                    if (shift_q == LAST_SHIFT) begin
                        state_d = S_RUN;
                        cyc_d   = '0;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    shift_d = shift_q;
                end
            end
            S_RUN: begin
                cyc_d = cyc_q + CYC_W'(1);
                if (bus.halt) begin
                    state_d = S_DUMP;
                    shift_d = '0;
                end else if ((max_q != '0) && (cyc_q == (max_q - CYC_W'(1)))) begin
                    state_d   = S_DUMP;
                    shift_d   = '0;
                    timeout_d = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DUMP: begin
                if (dump_shift_s) begin
                    shift_d = shift_q + CNT_W'(1);
                    if (pos_s == 3'd0) begin
                        asm_d = {7'b0000000, bus.scan_out};
                    end else begin
                        asm_d        = asm_q;
                        asm_d[pos_s] = bus.scan_out;
                    end
                    if ((pos_s == 3'd7) || (shift_q == LAST_SHIFT)) begin
                        dvalid_d = 1'b1;
                    end else begin
                        dvalid_d = 1'b0;
                    end
                end else if (dump_acc_s) begin
                    dvalid_d = 1'b0;
                    if (shift_q == CHAIN_END) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DUMP;
                    end
                end else begin
                    dvalid_d = dvalid_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops straight back to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            buf_q     <= 8'h00;
            buf_cnt_q <= 4'd0;
            owed_q    <= '0;
            shift_q   <= '0;
            cyc_q     <= '0;
            max_q     <= '0;
            timeout_q <= 1'b0;
            asm_q     <= 8'h00;
            dvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            buf_cnt_q <= buf_cnt_d;
            owed_q    <= owed_d;
            shift_q   <= shift_d;
            cyc_q     <= cyc_d;
            max_q     <= max_d;
            timeout_q <= timeout_d;
            asm_q     <= asm_d;
            dvalid_q  <= dvalid_d;
        end
    end
endmodule
